// File: rtl/regfile_storage_if.sv
// Bus bundle for the register-file storage array: write port, clear request,
// and the flattened parallel view of all 32 registers.
interface regfile_storage_if #(
  parameter int WIDTH = 64
);
  logic                   RegWrite;
  logic [4:0]             WriteRegister;
  logic [WIDTH-1:0]       WriteData;
  logic                   clear_req;
  logic                   busy;
  logic [32*WIDTH-1:0]    reg_q;

  modport master (
    output RegWrite, WriteRegister, WriteData, clear_req,
    input  busy, reg_q
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, clear_req,
    output busy, reg_q
  );
endinterface

// File: rtl/regfile_storage.sv
// 32-entry register-file storage with hardwired-zero register 31 and a
// sequential clear engine that zeroes registers 0..30 one per cycle.
module regfile_storage #(
  parameter int WIDTH = 64
) (
  input logic clk,
  input logic reset,
  regfile_storage_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  state_t           next_state;
  logic [4:0]       count;
  logic             last_clear;
  logic [WIDTH-1:0] regs [31];

  assign last_clear = (count == 5'd30);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.clear_req) next_state = CLEAR;
      CLEAR:   if (last_clear)    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == CLEAR);
  end

  // Requests arriving while the sweep runs are dropped; counter never restarts mid-sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 5'd0;
    end else if (state == IDLE) begin
      if (bus.clear_req) count <= 5'd0;
    end else begin
      count <= last_clear ? 5'd0 : count + 5'd1;
    end
  end

  // Only the sweep touches storage while clearing; index 31 has no storage at all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 31; i++) begin
        if (state == CLEAR) begin
          if (count == 5'(i)) regs[i] <= '0;
        end else if (bus.RegWrite && bus.WriteRegister == 5'(i)) begin
          regs[i] <= bus.WriteData;
        end
      end
    end
  end

  for (genvar n = 0; n < 31; n++) begin : g_out
    assign bus.reg_q[n*WIDTH +: WIDTH] = regs[n];
  end
  assign bus.reg_q[31*WIDTH +: WIDTH] = '0;

endmodule

// File: tb/tb_regfile_storage.sv
// Directed self-checking bench for regfile_storage: writes, zero register,
// clear sweep timing, collisions during clear and asynchronous reset.
module tb_regfile_storage;
  localparam int W = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] model [32];

  regfile_storage_if #(.WIDTH(W)) bus ();

  regfile_storage #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] idx,
                               input logic [W-1:0] data, input logic clr);
    bus.RegWrite      = we;
    bus.WriteRegister = idx;
    bus.WriteData     = data;
    bus.clear_req     = clr;
    tick();
    bus.RegWrite  = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs,
                             input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [32*W-1:0] exp;
    int bad;
    for (int n = 0; n < 32; n++) exp[n*W +: W] = model[n];
    checks++;
    assert (bus.reg_q === exp) else begin
      errors++;
      bad = 0;
      for (int n = 31; n >= 0; n--)
        if (bus.reg_q[n*W +: W] !== model[n]) bad = n;
      $error("FAIL %s: reg %0d observed %h expected %h",
             tag, bad, bus.reg_q[bad*W +: W], model[bad]);
    end
  endtask

  initial begin
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = 5'd0;
    bus.WriteData     = '0;
    bus.clear_req     = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset with the clock not yet having produced an edge.
    #1 reset = 1'b1;
    #1;
    checkOutput("reset_busy", {63'd0, bus.busy}, 64'd0);
    checkAll("reset_regs");
    #1 reset = 1'b0;

    // Basic writes.
    applyStimulus(1'b1, 5'd5, 64'hDEADBEEF_01234567, 1'b0);
    model[5] = 64'hDEADBEEF_01234567;
    checkOutput("write_r5", bus.reg_q[5*W +: W], 64'hDEADBEEF_01234567);
    checkAll("write_r5_all");
    applyStimulus(1'b1, 5'd30, 64'h1, 1'b0);
    model[30] = 64'h1;
    checkAll("write_r30_all");

    // Register 31 is hardwired zero.
    applyStimulus(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    checkOutput("r31_zero", bus.reg_q[31*W +: W], 64'd0);
    checkAll("r31_others");

    // Fill 0..30 with n+1, then full sweep.
    for (int n = 0; n < 31; n++) begin
      applyStimulus(1'b1, 5'(n), 64'(n + 1), 1'b0);
      model[n] = 64'(n + 1);
    end
    checkAll("fill");
    applyStimulus(1'b0, 5'd0, '0, 1'b1);
    checkOutput("clear_start_busy", {63'd0, bus.busy}, 64'd1);
    checkAll("clear_start_regs");
    for (int m = 1; m <= 31; m++) begin
      tick();
      model[m-1] = '0;
      checkAll($sformatf("sweep_e%0d", m));
      checkOutput($sformatf("sweep_busy_e%0d", m), {63'd0, bus.busy},
                  (m < 31) ? 64'd1 : 64'd0);
    end

    // Write and re-request during clear at counter 10.
    for (int n = 0; n < 31; n++) begin
      applyStimulus(1'b1, 5'(n), 64'(n + 1), 1'b0);
      model[n] = 64'(n + 1);
    end
    applyStimulus(1'b0, 5'd0, '0, 1'b1);
    for (int m = 1; m <= 10; m++) begin
      tick();
      model[m-1] = '0;
    end
    applyStimulus(1'b1, 5'd20, 64'hAA, 1'b1);
    model[10] = '0;
    checkAll("collide_e11");
    for (int m = 12; m <= 30; m++) begin
      tick();
      model[m-1] = '0;
    end
    checkOutput("collide_busy_e30", {63'd0, bus.busy}, 64'd1);
    // Request on the final sweep edge must not start another sweep.
    applyStimulus(1'b0, 5'd0, '0, 1'b1);
    model[30] = '0;
    checkOutput("collide_busy_e31", {63'd0, bus.busy}, 64'd0);
    checkAll("collide_done");
    tick();
    checkOutput("late_req_ignored", {63'd0, bus.busy}, 64'd0);

    // Simultaneous write and clear request in IDLE.
    applyStimulus(1'b1, 5'd3, 64'h55, 1'b1);
    checkOutput("simul_entry_r3", bus.reg_q[3*W +: W], 64'h55);
    checkOutput("simul_entry_busy", {63'd0, bus.busy}, 64'd1);
    tick(); tick(); tick();
    checkOutput("simul_e3_r3", bus.reg_q[3*W +: W], 64'h55);
    tick();
    checkOutput("simul_e4_r3", bus.reg_q[3*W +: W], 64'd0);
    for (int m = 5; m <= 31; m++) tick();
    checkOutput("simul_done_busy", {63'd0, bus.busy}, 64'd0);
    checkAll("simul_done");

    // Asynchronous reset mid-clear at counter 15.
    applyStimulus(1'b1, 5'd20, 64'h77, 1'b0);
    applyStimulus(1'b0, 5'd0, '0, 1'b1);
    for (int m = 1; m <= 15; m++) tick();
    checkOutput("pre_reset_r20", bus.reg_q[20*W +: W], 64'h77);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_busy", {63'd0, bus.busy}, 64'd0);
    checkAll("async_regs");
    #2 reset = 1'b0;
    applyStimulus(1'b1, 5'd7, 64'h1234, 1'b0);
    model[7] = 64'h1234;
    checkOutput("post_reset_r7", bus.reg_q[7*W +: W], 64'h1234);
    checkOutput("post_reset_busy", {63'd0, bus.busy}, 64'd0);
    checkAll("post_reset_all");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_storage.md
Name: regfile_storage

Overview:
Storage array of the 32-entry register file. It holds 32 registers of WIDTH bits and exposes every register bit in parallel, so each read-port bit slice is fed directly into a 32:1 bit-select mux.
- The block owns write decoding, the hardwired-zero register 31, and a sequential clear engine.
- The clear engine zeroes registers 0..30 one per cycle on request.

Parameters:
- WIDTH, 64, data width of each register.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high reset.
- RegWrite  input  1  write enable, sampled on clk rising edge.
- WriteRegister  input  5  destination register index, 0..31.
- WriteData  input  WIDTH  data to be written.
- clear_req  input  1  one-cycle request to start the sequential clear.
- busy  output  1  high while the clear engine is running.
- reg_q  output  32*WIDTH  flattened register contents; register n occupies bits [n*WIDTH +: WIDTH].

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While reset=1:
  - all 32 registers = 0, busy=0, state=IDLE, clear counter=0.
  - Takes effect immediately, independent of clk.
- Register 31: reg_q[31*WIDTH +: WIDTH] is constant 0 at all times.
  - Writes to index 31 are silently dropped and are not an error.
- Write, IDLE state:
  - At a clk rising edge with RegWrite=1 and WriteRegister=k (k≠31), register k <= WriteData.
  - The new value is visible on reg_q immediately after that edge (1-cycle latency, no bypass).
  - All other registers hold.
- reg_q is driven directly from the flops. It is purely registered, with no combinational path from any input.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR: clk edge with clear_req=1; counter <= 0; busy=1 from that edge.
  - CLEAR, each edge: register[counter] <= 0, then counter <= counter+1.
  - CLEAR -> IDLE: on the edge that zeroes register 30; busy=0 after that edge.
  - busy is therefore high for exactly 31 cycles per clear.
- Write during CLEAR (busy=1): RegWrite is ignored for all indices. Nothing other than the clear sequence modifies storage.
- clear_req during CLEAR: ignored; the counter does not restart.
- Simultaneous RegWrite and clear_req in IDLE:
  - The write commits on that edge and CLEAR starts on the same edge.
  - The written register is later zeroed by the sweep.
- clear_req on the same edge that CLEAR ends (counter=30): ignored. The FSM returns to IDLE; a new request is needed.
- Reset mid-clear: all registers zero, IDLE, busy=0 immediately. The counter does not resume.
- WriteRegister is a full 5-bit decode; no out-of-range indices exist.

Test Plan:
- Reset with WIDTH=64: assert reset with clk idle -> reg_q all 0 and busy=0 before any clk edge. Then deassert.
- Basic writes:
  - RegWrite=1, WriteRegister=5, WriteData=64'hDEADBEEF_01234567, one edge -> reg 5 holds it, all others 0.
  - Then WriteRegister=30, WriteData=64'h1 -> reg 30=1 and reg 5 is unchanged.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to index 31 -> reg 31 stays 0 and no other register changes.
- Clear sweep:
  - Fill regs 0..30 with value n+1, then pulse clear_req for 1 cycle.
  - busy is high for 31 cycles; after edge m (m=1..31), regs 0..m-1 are 0 and the rest hold n+1.
  - Afterwards busy=0 and all regs are 0.
- Collisions during clear:
  - During CLEAR at counter=10, write 64'hAA to index 20 and re-pulse clear_req -> write ignored, sweep not restarted, busy falls on schedule.
  - Simultaneous write 64'h55 to reg 3 plus clear_req in IDLE -> reg 3 reads 64'h55 for 3 cycles, then 0.
- Async reset mid-clear: assert reset between edges at counter=15 -> busy=0 and all regs 0 immediately. After release, a write to reg 7 works on the first edge.
